hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 14 +
 rtl/hazard_ctrl.sv | 46 ++++
 tb/tb_hazard_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs of the hazard unit.
interface hazard_ctrl_if;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_uses_rt, ex_memread, redirect;
   logic       pc_write, ifid_write, ifid_flush, idex_flush, busy;
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rd, ex_memread, redirect,
      input  pc_write, ifid_write, ifid_flush, idex_flush, busy
   );
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rd, ex_memread, redirect,
      output pc_write, ifid_write, ifid_flush, idex_flush, busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and branch/jump flush control with saturating perf counters.
module hazard_ctrl #(
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam logic [0:0] RUN    = 1'b0;
   localparam logic [0:0] FLUSH  = 1'b1;
   localparam logic [1:0] RELOAD = 2'(FLUSH_CYC - 1);
   logic [0:0] state, state_nx;
   logic [1:0] fcnt, fcnt_nx;
   logic       lu_hit, stall, flush;
   assign lu_hit = hz.ex_memread && hz.ex_rd != 5'd0 &&
                   (hz.ex_rd == hz.id_rs || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
   always_comb begin
      flush         = state == FLUSH || hz.redirect;
      stall         = state == RUN && !hz.redirect && lu_hit;
      state_nx      = hz.redirect ? (FLUSH_CYC > 1 ? FLUSH : RUN) :
                      (state == FLUSH && fcnt == 2'd1) ? RUN : state;
      fcnt_nx       = hz.redirect ? RELOAD : state == FLUSH ? fcnt - 2'd1 : fcnt;
      // reset holds the pipeline frozen and bubbled until release
      hz.pc_write   = rst && !stall;
      hz.ifid_write = rst && !stall;
      hz.ifid_flush = !rst || flush;
      hz.idex_flush = !rst || flush || stall;
      hz.busy       = rst && state == FLUSH;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         fcnt      <= 2'd0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nx;
         fcnt  <= fcnt_nx;
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three shared-stimulus instances (FLUSH_CYC 1/2/3, the last with 4-bit counters).
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic id_uses_rt = 1'b0, ex_memread = 1'b0, redirect = 1'b0;
   logic [4:0] outs [3];
   int sc [3], fc [3];
   int n_chk = 0, n_fail = 0;
   localparam logic [4:0] N = 5'b11000, S = 5'b00010, R = 5'b11110, F = 5'b11111, Z = 5'b00110;
   typedef struct { int d; logic [4:0] e; string nm; } exp_t;
   typedef struct { logic [4:0] rs, rt, rd; logic u, mr; logic [4:0] e; int sc; } vec_t;
   exp_t sb [$];
   vec_t vt [8];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : gd
      localparam int CW = (g == 2) ? 4 : 16;
      hazard_ctrl_if h ();
      logic [CW-1:0] st, fl;
      assign h.id_rs = id_rs;
      assign h.id_rt = id_rt;
      assign h.id_uses_rt = id_uses_rt;
      assign h.ex_rd = ex_rd;
      assign h.ex_memread = ex_memread;
      assign h.redirect = redirect;
      assign outs[g] = {h.pc_write, h.ifid_write, h.ifid_flush, h.idex_flush, h.busy};
      assign sc[g] = int'(st);
      assign fc[g] = int'(fl);
      hazard_ctrl #(.FLUSH_CYC(g + 1), .CNT_W(CW)) dut (
         .clk(clk), .rst(rst), .hz(h.slave), .stall_cnt(st), .flush_cnt(fl)
      );
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step(input string nm, input logic [4:0] rs, rt, rd, input logic u, mr, red,
                       input logic [4:0] e0, e1, e2);
      exp_t x;
      @(posedge clk);
      #1;
      id_rs = rs; id_rt = rt; ex_rd = rd; id_uses_rt = u; ex_memread = mr; redirect = red;
      sb.push_back('{0, e0, nm});
      sb.push_back('{1, e1, nm});
      sb.push_back('{2, e2, nm});
      #3;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         chk($sformatf("%s/d%0d", x.nm, x.d + 1), 32'(outs[x.d]), 32'(x.e));
      end
   endtask
   task automatic cnt_chk(input string nm, input int s0, s1, s2, input int f0, f1, f2);
      chk({nm, "_stall/d1"}, sc[0], s0); chk({nm, "_stall/d2"}, sc[1], s1); chk({nm, "_stall/d3"}, sc[2], s2);
      chk({nm, "_flush/d1"}, fc[0], f0); chk({nm, "_flush/d2"}, fc[1], f1); chk({nm, "_flush/d3"}, fc[2], f2);
   endtask
   initial begin
      vt[0] = '{5'd5,  5'd0, 5'd5,  1'b0, 1'b1, S, 0};
      vt[1] = '{5'd5,  5'd0, 5'd5,  1'b0, 1'b0, N, 1};
      vt[2] = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b1, N, 1};
      vt[3] = '{5'd1,  5'd7, 5'd7,  1'b0, 1'b1, N, 1};
      vt[4] = '{5'd1,  5'd7, 5'd7,  1'b1, 1'b1, S, 1};
      vt[5] = '{5'd3,  5'd4, 5'd5,  1'b1, 1'b1, N, 2};
      vt[6] = '{5'd31, 5'd2, 5'd31, 1'b1, 1'b1, S, 2};
      vt[7] = '{5'd9,  5'd9, 5'd9,  1'b1, 1'b0, N, 3};
      #2;
      for (int d = 0; d < 3; d++) chk($sformatf("reset_out/d%0d", d + 1), 32'(outs[d]), 32'(Z));
      cnt_chk("reset", 0, 0, 0, 0, 0, 0);
      #10 rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step($sformatf("vec%0d", i), vt[i].rs, vt[i].rt, vt[i].rd, vt[i].u, vt[i].mr, 1'b0,
              vt[i].e, vt[i].e, vt[i].e);
         for (int d = 0; d < 3; d++) chk($sformatf("vec%0d_stall/d%0d", i, d + 1), sc[d], vt[i].sc);
      end
      cnt_chk("table", 3, 3, 3, 0, 0, 0);
      step("prio_a", 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, R, R, R);
      step("prio_b", 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, S, F, F);
      step("prio_c", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, F);
      step("prio_d", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, N);
      cnt_chk("prio", 4, 3, 3, 1, 2, 3);
      step("refl_1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, R, R, R);
      step("refl_2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, R, F, F);
      step("refl_3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, F, F);
      step("refl_4", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, F);
      step("refl_5", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, N);
      cnt_chk("refl", 4, 3, 3, 3, 5, 7);
      for (int i = 0; i < 20; i++)
         step($sformatf("sat%0d", i), 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, S, S, S);
      step("sat_end", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, N);
      cnt_chk("sat", 24, 23, 15, 3, 5, 7);
      step("ar_red", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, R, R, R);
      @(posedge clk);
      #1 redirect = 1'b0;
      #1 rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("ar_out/d%0d", d + 1), 32'(outs[d]), 32'(Z));
      cnt_chk("ar", 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      step("ar_rel1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, N);
      step("ar_rel2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, N, N, N);
      cnt_chk("ar_rel", 0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
